// File: rtl/exec_wb_buffer.sv
// ---------------------------------------------------------------------------
// exec_wb_buffer
//
// Purpose:
//   Two-entry skid buffer between the single-operand exec units and the
//   register-file write port. Each entry holds an exec result together with
//   its {overflow, sign, zero, carry} flags, a destination index and two
//   enables. Entries drain in strict FIFO order. The architectural flags
//   register lives here and changes only when an entry with wr_flags set
//   retires.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, an input arriving while the buffer is empty
//                  and writeback is ready is presented on wb_* in the same
//                  cycle and retires without being stored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   synchronous flush, discards all buffered entries
//   in_valid_i   in   exec result valid
//   in_ready_o   out  buffer can accept this cycle (state-derived only)
//   result_i     in   exec result            [W_OPR-1:0]
//   flags_i      in   exec flags             [W_FLAGS-1:0]
//   dst_i        in   destination register   [W_RADDR-1:0]
//   wr_reg_i     in   entry writes the register file
//   wr_flags_i   in   entry updates architectural flags
//   wb_valid_o   out  head entry valid
//   wb_ready_i   in   writeback accepts head
//   wb_data_o    out  head result           [W_OPR-1:0]
//   wb_addr_o    out  head destination      [W_RADDR-1:0]
//   wb_we_o      out  wb_valid_o & head wr_reg
//   flags_o      out  architectural flags register [W_FLAGS-1:0]
//   count_o      out  occupancy, 0..2
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer; ready never depends combinationally on
// the other side's ready. flush_i overrides both transfers for that cycle.
// ---------------------------------------------------------------------------
module exec_wb_buffer #(
    parameter int W_OPR   = 32,
    parameter int W_FLAGS = 4,
    parameter int W_RADDR = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [W_OPR-1:0]   result_i,
    input  logic [W_FLAGS-1:0] flags_i,
    input  logic [W_RADDR-1:0] dst_i,
    input  logic               wr_reg_i,
    input  logic               wr_flags_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [W_OPR-1:0]   wb_data_o,
    output logic [W_RADDR-1:0] wb_addr_o,
    output logic               wb_we_o,
    output logic [W_FLAGS-1:0] flags_o
    ,
    output logic [1:0]         count_o
);

    // Entry storage (not reset: contents are meaningless while count is 0)
    logic [W_OPR-1:0]   res_mem   [2];
    logic [W_FLAGS-1:0] flg_mem   [2];
    logic [W_RADDR-1:0] dst_mem   [2];
    logic               wreg_mem  [2];
    logic               wflg_mem  [2];

    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         count_q, count_d;
    logic [W_FLAGS-1:0] flags_q, flags_d;

    // Head entry as seen by writeback
    logic [W_OPR-1:0]   head_res;
    logic [W_FLAGS-1:0] head_flg;
    logic [W_RADDR-1:0] head_dst;
    logic               head_wreg;
    logic               head_wflg;

    logic               accept;
    logic               retire;
    logic               push;
    logic               pop;

    // Full is the only reason to refuse input; it is a pure function of
    // state, so there is no path from wb_ready_i back to exec.
    assign in_ready_o = (count_q != 2'd2);

`ifdef WB_BYPASS_EN
    logic byp;
    logic take_byp;

    // Empty buffer, input valid and writeback ready: the input entry goes
    // straight to the write port this cycle.
    assign byp = (count_q == 2'd0) & in_valid_i & wb_ready_i;

    assign wb_valid_o = (count_q != 2'd0) | byp;
    assign head_res   = byp ? result_i   : res_mem[rptr_q];
    assign head_flg   = byp ? flags_i    : flg_mem[rptr_q];
    assign head_dst   = byp ? dst_i      : dst_mem[rptr_q];
    assign head_wreg  = byp ? wr_reg_i   : wreg_mem[rptr_q];
    assign head_wflg  = byp ? wr_flags_i : wflg_mem[rptr_q];
    assign take_byp   = byp & ~flush_i;
`else
    assign wb_valid_o = (count_q != 2'd0);
    assign head_res   = res_mem[rptr_q];
    assign head_flg   = flg_mem[rptr_q];
    assign head_dst   = dst_mem[rptr_q];
    assign head_wreg  = wreg_mem[rptr_q];
    assign head_wflg  = wflg_mem[rptr_q];
`endif

    assign wb_data_o = head_res;
    assign wb_addr_o = head_dst;
    assign wb_we_o   = wb_valid_o & head_wreg;
    assign flags_o   = flags_q;
    assign count_o   = count_q;

    // Flush suppresses both transfers so nothing retires or lands in storage.
    assign accept = in_valid_i & in_ready_o & ~flush_i;
    assign retire = wb_valid_o & wb_ready_i & ~flush_i;

`ifdef WB_BYPASS_EN
    // A bypassed entry is accepted and retired in the same cycle without
    // ever occupying a slot.
    assign push = accept & ~take_byp;
    assign pop  = retire & ~take_byp;
`else
    assign push = accept;
    assign pop  = retire;
`endif

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        flags_d = flags_q;

        if (flush_i) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            if (retire && head_wflg) flags_d = head_flg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wptr_q]  <= result_i;
            flg_mem[wptr_q]  <= flags_i;
            dst_mem[wptr_q]  <= dst_i;
            wreg_mem[wptr_q] <= wr_reg_i;
            wflg_mem[wptr_q] <= wr_flags_i;
        end
    end

endmodule

// File: tb/tb_exec_wb_buffer.sv
module tb_exec_wb_buffer;

  localparam int W_OPR   = 32;
  localparam int W_FLAGS = 4;
  localparam int W_RADDR = 5;
  localparam int W_ENT   = W_OPR + W_FLAGS + W_RADDR + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               flush_i = 1'b0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [W_OPR-1:0]   result_i = '0;
  logic [W_FLAGS-1:0] flags_i = '0;
  logic [W_RADDR-1:0] dst_i = '0;
  logic               wr_reg_i = 1'b0;
  logic               wr_flags_i = 1'b0;
  logic               wb_valid_o;
  logic               wb_ready_i = 1'b0;
  logic [W_OPR-1:0]   wb_data_o;
  logic [W_RADDR-1:0] wb_addr_o;
  logic               wb_we_o;
  logic [W_FLAGS-1:0] flags_o;
  logic [1:0]         count_o;

  exec_wb_buffer #(.W_OPR(W_OPR), .W_FLAGS(W_FLAGS), .W_RADDR(W_RADDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .result_i   (result_i),
    .flags_i    (flags_i),
    .dst_i      (dst_i),
    .wr_reg_i   (wr_reg_i),
    .wr_flags_i (wr_flags_i),
    .wb_valid_o (wb_valid_o),
    .wb_ready_i (wb_ready_i),
    .wb_data_o  (wb_data_o),
    .wb_addr_o  (wb_addr_o),
    .wb_we_o    (wb_we_o),
    .flags_o    (flags_o),
    .count_o    (count_o)
  );

  // ---------------- scoreboard ----------------
  // entry = {result, flags, dst, wr_reg, wr_flags}
  logic [W_ENT-1:0]   exp_q[$];
  logic [W_FLAGS-1:0] exp_flags = '0;
  int                 n_checks = 0;
  int                 n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver: one cycle ----------------
  // Called just after a rising edge. Drives inputs, checks outputs against
  // the model mid-cycle, then advances the model across the next edge.
  task automatic step(input logic inv, input logic [W_OPR-1:0] res,
                      input logic [W_FLAGS-1:0] fl, input logic [W_RADDR-1:0] dst,
                      input logic wr, input logic wf, input logic wbr,
                      input logic fls);
    logic [W_ENT-1:0] in_ent;
    logic [W_ENT-1:0] head;
    logic             exp_ready;
    logic             exp_valid;
    logic             bypass;
    in_valid_i = inv; result_i = res; flags_i = fl; dst_i = dst;
    wr_reg_i = wr; wr_flags_i = wf; wb_ready_i = wbr; flush_i = fls;
    in_ent = {res, fl, dst, wr, wf};
    #2;
    exp_ready = (exp_q.size() < 2);
    bypass = 1'b0;
`ifdef WB_BYPASS_EN
    bypass = (exp_q.size() == 0) && inv && wbr;
`endif
    exp_valid = (exp_q.size() != 0) || bypass;
    head = bypass ? in_ent : ((exp_q.size() != 0) ? exp_q[0] : '0);
    check("count", 64'(count_o), 64'(exp_q.size()));
    check("in_ready", 64'(in_ready_o), 64'(exp_ready));
    check("wb_valid", 64'(wb_valid_o), 64'(exp_valid));
    check("flags", 64'(flags_o), 64'(exp_flags));
    check("wb_we", 64'(wb_we_o), 64'(exp_valid && head[1]));
    if (exp_valid) begin
      check("wb_data", 64'(wb_data_o), 64'(head[W_ENT-1 -: W_OPR]));
      check("wb_addr", 64'(wb_addr_o), 64'(head[W_RADDR+1:2]));
    end
    // model update for the coming edge
    if (fls) begin
      exp_q.delete();
    end else begin
      if (exp_valid && wbr) begin
        if (head[0]) exp_flags = head[W_RADDR+2 +: W_FLAGS];
        if (!bypass) void'(exp_q.pop_front());
      end
      if (inv && exp_ready && !bypass) exp_q.push_back(in_ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wbr);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, wbr, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state while held in reset
    #12;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_flags", 64'(flags_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single pass
    step(1'b1, 32'h0000_0005, 4'b0000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // backpressure fill: A, B, then a refused third push
    step(1'b1, 32'h8000_0000, 4'b0100, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 4'b0010, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 4'b1001, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // wr_flags gating: flags_o is 0010 here
    step(1'b1, 32'hFFFF_FFFF, 4'b1111, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h1234_5678, 4'b1111, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // streaming at count 1 across pointer wrap
    step(1'b1, 32'd100, 4'b0001, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'(101 + i), 4'(i), 5'(i), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // flush at count 2 with accept and retire requested
    step(1'b1, 32'hAAAA_0001, 4'b1000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0002, 4'b0101, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0003, 4'b0011, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 5'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));

    // reset mid-traffic with count 2 and nonzero flags
    step(1'b1, 32'h0000_00F0, 4'b1010, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 32'h0000_00F1, 4'b0110, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00F2, 4'b0111, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    wb_ready_i = 1'b0;
    #1;
    check("pre_rst_count", 64'(count_o), 64'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count_o), 64'd0);
    check("async_rst_flags", 64'(flags_o), 64'd0);
    check("async_rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("async_rst_wb_we", 64'(wb_we_o), 64'd0);
    check("async_rst_in_ready", 64'(in_ready_o), 64'd1);
    exp_q.delete();
    exp_flags = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h0000_0042, 4'b1100, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
